// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer feeding the IR: owns the PC, strobes instruction RAM, buffers the
// returned word and pulses IR_Load once per fetch. Stops for good on a HALT opcode.
module instruction_fetch_unit #(
  parameter int unsigned INST_WIDTH  = 21,
  parameter int unsigned PC_WIDTH    = 6,
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [2:0]  HALT_OPCODE = 3'b111
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  Next_Inst,
  input  logic                  Jump,
  input  logic [PC_WIDTH-1:0]   Jump_Addr,
  input  logic [INST_WIDTH-1:0] Ram_Inst_In,
  output logic                  Ram_Rd_En,
  output logic [PC_WIDTH-1:0]   Ram_Addr,
  output logic [INST_WIDTH-1:0] Ram_Inst_Out,
  output logic                  IR_Load,
  output logic [PC_WIDTH-1:0]   PC,
  output logic                  Halted,
  output logic                  Fetch_Busy
);

  localparam int unsigned CNT_W = $clog2(RAM_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_HOLD,
    S_HALT
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nx;
  logic [PC_WIDTH-1:0]     pc_nx;
  logic [INST_WIDTH-1:0]   inst_nx;

  // State, counter, PC and instruction buffer; outputs are registered from the next state
  // so they line up exactly with the state they describe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      PC           <= '0;
      Ram_Inst_Out <= '0;
      Ram_Rd_En    <= 1'b0;
      Ram_Addr     <= '0;
      IR_Load      <= 1'b0;
      Halted       <= 1'b0;
      Fetch_Busy   <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      PC           <= pc_nx;
      Ram_Inst_Out <= inst_nx;
      Ram_Rd_En    <= (state_nx == S_REQ);
      Ram_Addr     <= (state_nx == S_REQ) ? pc_nx : '0;
      IR_Load      <= (state_nx == S_LOAD);
      Halted       <= (state_nx == S_HALT);
      Fetch_Busy   <= (state_nx inside {S_REQ, S_WAIT, S_LOAD});
    end
  end

  // Next-state, PC and buffer update
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = PC;
    inst_nx  = Ram_Inst_Out;
    case (state)
      S_IDLE: begin
        if (Run) state_nx = S_REQ;
      end
      S_REQ: begin
        cnt_nx   = CNT_W'(RAM_LATENCY);
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          inst_nx  = Ram_Inst_In;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        pc_nx    = PC + PC_WIDTH'(1);
        state_nx = (Ram_Inst_Out[INST_WIDTH-1 -: 3] == HALT_OPCODE) ? S_HALT : S_HOLD;
      end
      S_HOLD: begin
        // A jump target is taken even when the fetch stream is being parked in IDLE
        if (Next_Inst) begin
          if (Jump) pc_nx = Jump_Addr;
          state_nx = Run ? S_REQ : S_IDLE;
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
